// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES decryption controller.
//   op_t         : datapath operation committed in a given cycle
//   ctrl_state_t : controller FSM state encoding (also exported for debug)
//   NUM_ROUNDS   : AES-128 round count (last round-key index)
//   IMC_WORDS    : number of 32-bit columns mixed by InvMixColumns
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ARK,
        OP_ISR,
        OP_ISB,
        OP_IMC
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_KEY,
        ARK,
        ISR,
        ISB,
        IMC,
        DONE
    } ctrl_state_t;

    localparam int NUM_ROUNDS = 10;
    localparam int IMC_WORDS  = 4;

endpackage

// File: rtl/aes_decrypt_ctrl.sv
// ---------------------------------------------------------------------------
// aes_decrypt_ctrl
// Sequencer for an AES-128 inverse cipher. Owns the 128-bit working state and
// steps it through AddRoundKey / InvShiftRows / InvSubBytes / InvMixColumns,
// whose results are computed outside this block from state_q.
//
// Ports
//   Clk, Reset_n   : clock, asynchronous active-low reset
//   start          : level request; accepted only in IDLE
//   key_ready      : round keys available; only looked at in WAIT_KEY
//   cipher_in      : ciphertext, captured when start is accepted
//   ark_in         : state_q XOR round key[Round]
//   isr_in, isb_in : InvShiftRows(state_q), InvSubBytes(state_q)
//   imc_word_in    : InvMixColumns of column mix_sel of state_q
//   state_q        : working state (plaintext once done)
//   Round          : round-key index used by AddRoundKey
//   op             : operation committed this cycle
//   mix_sel        : column being mixed during IMC
//   busy, done     : status
//   dbg_state_o    : current FSM state, for observation only
//
// Handshake: start is a level. It is sampled only in IDLE; once accepted the
// block is busy and ignores start. On completion the block sits in DONE with
// done=1 for as long as start stays high; dropping start returns it to IDLE
// on the next edge, so the requester owns the release of the result.
// ---------------------------------------------------------------------------
module aes_decrypt_ctrl
    import aes_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic         key_ready,
    input  logic [127:0] cipher_in,
    input  logic [127:0] ark_in,
    input  logic [127:0] isr_in,
    input  logic [127:0] isb_in,
    input  logic [31:0]  imc_word_in,
    output logic [127:0] state_q,
    output logic [3:0]   Round,
    output op_t          op,
    output logic [1:0]   mix_sel,
    output logic         busy,
    output logic         done,
    output ctrl_state_t  dbg_state_o
);

    ctrl_state_t  fsm_q, fsm_d;
    logic [127:0] state_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   mix_q, mix_d;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [1:0] LAST_WORD  = 2'(IMC_WORDS - 1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            mix_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            mix_q   <= mix_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        mix_d   = mix_q;
        op      = OP_NONE;

        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = cipher_in;
                    round_d = '0;
                    mix_d   = '0;
                    fsm_d   = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (key_ready) begin
                    fsm_d = ARK;
                end
            end
            ARK: begin
                op      = OP_ARK;
                state_d = ark_in;
                // Round 0 is the initial whitening key; round 10 is the last
                // key and has no InvMixColumns after it.
                if (round_q == 4'd0) begin
                    round_d = 4'd1;
                    fsm_d   = ISR;
                end else if (round_q == LAST_ROUND) begin
                    fsm_d = DONE;
                end else begin
                    mix_d = '0;
                    fsm_d = IMC;
                end
            end
            ISR: begin
                op      = OP_ISR;
                state_d = isr_in;
                fsm_d   = ISB;
            end
            ISB: begin
                op      = OP_ISB;
                state_d = isb_in;
                fsm_d   = ARK;
            end
            IMC: begin
                op = OP_IMC;
                // Column mix_sel occupies the word starting at the MSB end.
                case (mix_q)
                    2'd0:    state_d[127:96] = imc_word_in;
                    2'd1:    state_d[95:64]  = imc_word_in;
                    2'd2:    state_d[63:32]  = imc_word_in;
                    default: state_d[31:0]   = imc_word_in;
                endcase
                if (mix_q == LAST_WORD) begin
                    mix_d   = '0;
                    round_d = round_q + 4'd1;
                    fsm_d   = ISR;
                end else begin
                    mix_d = mix_q + 2'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    assign Round       = round_q;
    assign mix_sel     = mix_q;
    assign busy        = (fsm_q != IDLE) && (fsm_q != DONE);
    assign done        = (fsm_q == DONE);
    assign dbg_state_o = fsm_q;

endmodule
